// File: rtl/xor_stream_pkg.sv
// Shared types and helpers for the XOR stream accumulator.
package xor_stream_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int cnt_w(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/xor_reduce.sv
// Combinational reduction-XOR of one word; a WIDTH=2 instance is the classic 2-input XOR gate.
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    assign parity = ^data;

endmodule

// File: rtl/xor_stream_accum.sv
// Folds a frame of words into an XOR signature, parity bit and saturating beat count.
// Optional expected-signature compare is enabled by defining XOR_CHECK_EN.
module xor_stream_accum
    import xor_stream_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_WORDS = 16,
    localparam int CW       = cnt_w(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
`ifdef XOR_CHECK_EN
    input  logic [WIDTH-1:0] in_expect,
    output logic             out_mismatch,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_xor,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] out_xor_q, out_xor_d;
    logic             out_parity_q, out_parity_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             out_overflow_q, out_overflow_d;
`ifdef XOR_CHECK_EN
    logic             out_mismatch_q, out_mismatch_d;
`endif

    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt_next;
    logic             ovf_next;
    logic             parity_next;
    logic             at_max;

    assign at_max   = (cnt_q == CW'(MAX_WORDS));
    assign acc_next = acc_q ^ in_data;
    assign cnt_next = at_max ? cnt_q : cnt_q + CW'(1);
    assign ovf_next = ovf_q | at_max;

    xor_reduce #(.WIDTH(WIDTH)) u_parity (
        .data   (acc_next),
        .parity (parity_next)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a signal unassigned (no latches).
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        out_xor_d      = out_xor_q;
        out_parity_d   = out_parity_q;
        out_count_d    = out_count_q;
        out_overflow_d = out_overflow_q;
`ifdef XOR_CHECK_EN
        out_mismatch_d = out_mismatch_q;
`endif
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (in_last) begin
                        // Last beat: publish the folded result and start the next frame clean.
                        out_xor_d      = acc_next;
                        out_parity_d   = parity_next;
                        out_count_d    = cnt_next;
                        out_overflow_d = ovf_next;
`ifdef XOR_CHECK_EN
                        out_mismatch_d = (acc_next != in_expect);
`endif
                        acc_d          = '0;
                        cnt_d          = '0;
                        ovf_d          = 1'b0;
                        state_d        = HOLD;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_next;
                        ovf_d = ovf_next;
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ACCUM;
            acc_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            out_xor_q      <= '0;
            out_parity_q   <= 1'b0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
`ifdef XOR_CHECK_EN
            out_mismatch_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            out_xor_q      <= out_xor_d;
            out_parity_q   <= out_parity_d;
            out_count_q    <= out_count_d;
            out_overflow_q <= out_overflow_d;
`ifdef XOR_CHECK_EN
            out_mismatch_q <= out_mismatch_d;
`endif
        end
    end

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign out_xor      = out_xor_q;
    assign out_parity   = out_parity_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_overflow_q;
`ifdef XOR_CHECK_EN
    assign out_mismatch = out_mismatch_q;
`endif

endmodule

// File: tb/tb_xor_stream_accum.sv
// Bench for xor_stream_accum: directed cases plus randomized frames checked by a queue scoreboard.
module tb_xor_stream_accum;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 4;
    localparam int CW        = $clog2(MAX_WORDS + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic [WIDTH-1:0] in_expect = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_xor;
    logic             out_parity;
    logic [CW-1:0]    out_count;
    logic             out_overflow;
`ifdef XOR_CHECK_EN
    logic             out_mismatch;
`endif

    xor_stream_accum #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
`ifdef XOR_CHECK_EN
        .in_expect    (in_expect),
        .out_mismatch (out_mismatch),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_xor      (out_xor),
        .out_parity   (out_parity),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic             p;
        int               cnt;
        logic             ovf;
        logic             mis;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] frame[$];
    bit               busy = 1'b0;
    bit               mon_en = 1'b0;
    bit               rand_ready = 1'b0;
    bit               forced_ready = 1'b1;
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // out_ready driver: random in the soak phase, otherwise whatever the directed code asks for.
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : forced_ready;
    end

    // Reference model: frame-level view of the handshake rules, evaluated on each edge.
    always @(posedge clk) begin
        if (rst) begin
            frame.delete();
            exp_q.delete();
            busy = 1'b0;
        end else if (busy) begin
            if (out_ready) busy = 1'b0;
        end else if (in_valid) begin
            frame.push_back(in_data);
            if (in_last) begin
                exp_t e;
                e.x = '0;
                foreach (frame[i]) e.x ^= frame[i];
                e.p   = ^e.x;
                e.cnt = (frame.size() > MAX_WORDS) ? MAX_WORDS : frame.size();
                e.ovf = (frame.size() > MAX_WORDS);
                e.mis = (e.x != in_expect);
                exp_q.push_back(e);
                frame.delete();
                busy = 1'b1;
            end
        end
    end

    // Monitor: compares every presented result against the scoreboard head, pops on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            check("sb_in_ready", in_ready, !busy);
            check("sb_out_valid", out_valid, busy);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    check("sb_xor", out_xor, exp_q[0].x);
                    check("sb_parity", out_parity, exp_q[0].p);
                    check("sb_count", out_count, exp_q[0].cnt);
                    check("sb_overflow", out_overflow, exp_q[0].ovf);
`ifdef XOR_CHECK_EN
                    check("sb_mismatch", out_mismatch, exp_q[0].mis);
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_beat(input logic [WIDTH-1:0] d, input logic l, input logic [WIDTH-1:0] e);
        int waited = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        in_expect = e;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_result(input logic [WIDTH-1:0] x, input logic p, input int c,
                                input logic o, input logic m);
        @(negedge clk);
        check("res_valid", out_valid, 1);
        check("res_xor", out_xor, x);
        check("res_parity", out_parity, p);
        check("res_count", out_count, c);
        check("res_overflow", out_overflow, o);
`ifdef XOR_CHECK_EN
        check("res_mismatch", out_mismatch, m);
`else
        if (m === 1'bx) check("res_mismatch_arg", 0, 1);
`endif
    endtask

    initial begin
        logic [WIDTH-1:0] rx;
        int               waited;

        // 1. Reset for two cycles.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_xor", out_xor, 0);
        check("rst_out_parity", out_parity, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_overflow", out_overflow, 0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // 2. Three-beat frame.
        send_beat(8'h0F, 1'b0, 8'h00);
        send_beat(8'hF0, 1'b0, 8'h00);
        send_beat(8'h3C, 1'b1, 8'hC3);
        check_result(8'hC3, 1'b0, 3, 1'b0, 1'b0);

        // 3. Single-beat frame.
        send_beat(8'h01, 1'b1, 8'h01);
        check_result(8'h01, 1'b1, 1, 1'b0, 1'b0);

        // 4. Back-pressure: result held, offered beats ignored.
        forced_ready = 1'b0;
        @(posedge clk);
        #2;
        send_beat(8'h12, 1'b0, 8'h00);
        send_beat(8'h34, 1'b1, 8'h26);
        check_result(8'h26, 1'b1, 2, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h99;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_xor", out_xor, 8'h26);
            check("hold_count", out_count, 2);
        end
        in_valid     = 1'b0;
        forced_ready = 1'b1;
        send_beat(8'h77, 1'b1, 8'h77);
        check_result(8'h77, 1'b0, 1, 1'b0, 1'b0);

        // 5. Overflow: six beats against MAX_WORDS=4, then a normal frame.
        for (int i = 0; i < 6; i++) send_beat(8'hFF, (i == 5), 8'h00);
        check_result(8'h00, 1'b0, 4, 1'b1, 1'b0);
        send_beat(8'h10, 1'b0, 8'h00);
        send_beat(8'h20, 1'b1, 8'h30);
        check_result(8'h30, 1'b0, 2, 1'b0, 1'b0);

        // 6. Reset mid-frame discards the partial accumulation.
        send_beat(8'h11, 1'b0, 8'h00);
        send_beat(8'h22, 1'b0, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send_beat(8'hAA, 1'b1, 8'hAB);
        check_result(8'hAA, 1'b0, 1, 1'b0, 1'b1);

        // Reset while a result is held drops it.
        forced_ready = 1'b0;
        @(posedge clk);
        #2;
        send_beat(8'h5A, 1'b1, 8'h5A);
        check_result(8'h5A, 1'b0, 1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hold_valid", out_valid, 0);
        check("rst_hold_xor", out_xor, 0);
        forced_ready = 1'b1;

        // Randomized frames with idle gaps and random consumer stalls.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(1, 7);
            rx = '0;
            for (int b = 0; b < len; b++) begin
                logic [WIDTH-1:0] d = WIDTH'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    in_data = WIDTH'($urandom);
                    in_last = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                rx ^= d;
                send_beat(d, (b == len - 1), ($urandom_range(0, 1) != 0) ? rx : WIDTH'($urandom));
            end
        end

        rand_ready   = 1'b0;
        forced_ready = 1'b1;
        waited = 0;
        while ((exp_q.size() != 0 || out_valid) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
